pll_reset_sequencer: RTL
========================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_rst is held high per PLL reset pulse (range 1..255).
REQ-002 SHALL have parameter LOCK_FILTER, default 1024, consecutive synchronized-lock cycles required before release (range 2..65535).
REQ-003 SHALL have parameter RELOCK_TIMEOUT, default 1048576, WAIT_LOCK cycles before a fresh PLL reset is issued (must exceed LOCK_FILTER).
REQ-004 SHALL have port: clkin  input  1  single clock, the 25 MHz board clock feeding the PLL.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: pll_locked  input  1  PLL lock output, asynchronous to clkin.
REQ-007 SHALL have port: force_relock  input  1  single-cycle request to re-run the PLL reset sequence.
REQ-008 SHALL have port: pll_rst  output  1  drives the PLL RST pin, active-high.
REQ-009 SHALL have port: sys_rst_n  output  1  active-low reset for downstream logic.
REQ-010 SHALL have port: ready  output  1  high only in RUN.
REQ-011 SHALL have port: state  output  2  current state encoding.
REQ-012 SHALL have port: relock_count  output  8  count of lock losses/forced relocks since reset, saturating.

Function
REQ-013 SHALL pass pll_locked through a 2-flop synchronizer; lock_s (its output) lags pll_locked by 2 clkin cycles; all decisions use lock_s only.
REQ-014 SHALL implement states RESET_PLL=0, WAIT_LOCK=1, RUN=2; encoding 3 is unreachable and SHALL transition to RESET_PLL.
REQ-015 RESET_PLL: pll_rst=1, sys_rst_n=0; a counter runs PLL_RST_CYCLES cycles, then the block enters WAIT_LOCK with pll_rst=0 on the next edge.
REQ-016 WAIT_LOCK: pll_rst=0, sys_rst_n=0; filter counter increments on each cycle lock_s=1 and clears to 0 on any cycle lock_s=0.
REQ-017 WAIT_LOCK: when filter counter reaches LOCK_FILTER, the block enters RUN on that edge.
REQ-018 WAIT_LOCK: a timeout counter, cleared on entry, increments every cycle; on reaching RELOCK_TIMEOUT with the filter incomplete, the block enters RESET_PLL; relock_count is not incremented.
REQ-019 If filter completion and timeout coincide, filter completion SHALL win (enter RUN).
REQ-020 RUN: sys_rst_n=1, ready=1, pll_rst=0.
REQ-021 RUN: lock_s=0 for one cycle SHALL cause entry to RESET_PLL on that edge; sys_rst_n and ready fall together, registered, in the same cycle as the state change; relock_count increments by 1.
REQ-022 force_relock=1 in WAIT_LOCK or RUN SHALL cause entry to RESET_PLL; relock_count increments by 1; force_relock is ignored in RESET_PLL (counter restarts not required).
REQ-023 Lock loss and force_relock in the same RUN cycle SHALL increment relock_count once.
REQ-024 relock_count SHALL saturate at 255.
REQ-025 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-026 Counters SHALL be sized by $clog2 of their parameter +1; no wrap-around is reachable.

Reset
REQ-027 rst_n low SHALL asynchronously force: state=RESET_PLL, pll_rst=1, sys_rst_n=0, ready=0, relock_count=0, all counters and synchronizer flops 0.
REQ-028 After rst_n deasserts, RESET_PLL SHALL run its full PLL_RST_CYCLES; rst_n assertion mid-sequence in any state restarts from REQ-027.

Structure
REQ-029 A shared package pll_seq_pkg SHALL hold the state enum/encoding constants and the relock_count width.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named sync2 (async active-low reset, reset value 0).

Verification (bench parameters: PLL_RST_CYCLES=4, LOCK_FILTER=8, RELOCK_TIMEOUT=64)
REQ-031 Release rst_n, pll_locked=1 from cycle 0 -> pll_rst high 4 cycles, then sys_rst_n=1, ready=1, state=2 after 2-cycle sync + 8 filter cycles.
REQ-032 pll_locked toggles 1-for-5/0-for-1 in WAIT_LOCK -> never reaches RUN; at 64 cycles returns to state=0, pll_rst pulses 4 cycles, relock_count stays 0.
REQ-033 In RUN, pll_locked low 1 cycle -> 2 cycles later sys_rst_n=0, ready=0, state=0, relock_count=1, full 4-cycle pll_rst pulse follows.
REQ-034 In RUN, force_relock pulse coinciding with lock_s low -> relock_count increments by exactly 1.
REQ-035 Force 256 relocks -> relock_count reads 255 and stays 255.
REQ-036 Assert rst_n low mid-WAIT_LOCK -> outputs immediately (asynchronously) return to REQ-027 values; sequence restarts on release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer: state encoding and
// relock counter width with its saturating increment.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } pll_state_e;

  localparam int unsigned RELOCK_CNT_W = 8;
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_CNT_MAX = '1;

  function automatic logic [RELOCK_CNT_W-1:0] relock_sat_inc(
    input logic [RELOCK_CNT_W-1:0] v
  );
    return (v == RELOCK_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the local clock
// domain; both flops clear to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a filtered lock, then releases downstream
// reset; re-runs the sequence on lock loss, forced relock or lock timeout.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_FILTER    = 1024,
  parameter int unsigned RELOCK_TIMEOUT = 1048576
) (
  input  logic                    clkin,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic                    force_relock,
  output logic                    pll_rst,
  output logic                    sys_rst_n,
  output logic                    ready,
  output logic [1:0]              state,
  output logic [RELOCK_CNT_W-1:0] relock_count
);

  localparam int unsigned RST_CNT_W = $clog2(PLL_RST_CYCLES) + 1;
  localparam int unsigned FILT_W    = $clog2(LOCK_FILTER) + 1;
  localparam int unsigned TMO_W     = $clog2(RELOCK_TIMEOUT) + 1;

  pll_state_e              r_state;
  logic                    r_pll_rst;
  logic                    r_sys_rst_n;
  logic                    r_ready;
  logic [RELOCK_CNT_W-1:0] r_relock_cnt;
  logic [RST_CNT_W-1:0]    r_rst_cnt;
  logic [FILT_W-1:0]       r_filt_cnt;
  logic [TMO_W-1:0]        r_tmo_cnt;

  logic                    w_lock_s;
  logic [FILT_W-1:0]       w_filt_next;
  logic [TMO_W-1:0]        w_tmo_next;
  logic                    w_filt_done;
  logic                    w_tmo_done;
  logic                    w_rst_done;

  sync2 u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_lock_s)
  );

  // Lock filter restarts on any unlocked cycle; decisions look at the next value.
  assign w_filt_next = w_lock_s ? (r_filt_cnt + 1'b1) : '0;
  assign w_tmo_next  = r_tmo_cnt + 1'b1;
  assign w_filt_done = (w_filt_next == FILT_W'(LOCK_FILTER));
  assign w_tmo_done  = (w_tmo_next == TMO_W'(RELOCK_TIMEOUT));
  assign w_rst_done  = (r_rst_cnt == RST_CNT_W'(PLL_RST_CYCLES - 1));

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RESET_PLL;
      r_pll_rst    <= 1'b1;
      r_sys_rst_n  <= 1'b0;
      r_ready      <= 1'b0;
      r_relock_cnt <= '0;
      r_rst_cnt    <= '0;
      r_filt_cnt   <= '0;
      r_tmo_cnt    <= '0;
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          if (w_rst_done) begin
            r_state    <= ST_WAIT_LOCK;
            r_pll_rst  <= 1'b0;
            r_rst_cnt  <= '0;
            r_filt_cnt <= '0;
            r_tmo_cnt  <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end

        // A forced relock beats both filter completion and timeout.
        ST_WAIT_LOCK: begin
          if (force_relock) begin
            r_state      <= ST_RESET_PLL;
            r_pll_rst    <= 1'b1;
            r_rst_cnt    <= '0;
            r_relock_cnt <= relock_sat_inc(r_relock_cnt);
          end else if (w_filt_done) begin
            r_state     <= ST_RUN;
            r_sys_rst_n <= 1'b1;
            r_ready     <= 1'b1;
          end else if (w_tmo_done) begin
            r_state   <= ST_RESET_PLL;
            r_pll_rst <= 1'b1;
            r_rst_cnt <= '0;
          end else begin
            r_filt_cnt <= w_filt_next;
            r_tmo_cnt  <= w_tmo_next;
          end
        end

        ST_RUN: begin
          if (!w_lock_s || force_relock) begin
            r_state      <= ST_RESET_PLL;
            r_pll_rst    <= 1'b1;
            r_sys_rst_n  <= 1'b0;
            r_ready      <= 1'b0;
            r_rst_cnt    <= '0;
            r_relock_cnt <= relock_sat_inc(r_relock_cnt);
          end
        end

        default: begin
          r_state     <= ST_RESET_PLL;
          r_pll_rst   <= 1'b1;
          r_sys_rst_n <= 1'b0;
          r_ready     <= 1'b0;
          r_rst_cnt   <= '0;
        end
      endcase
    end
  end

  assign pll_rst      = r_pll_rst;
  assign sys_rst_n    = r_sys_rst_n;
  assign ready        = r_ready;
  assign state        = r_state;
  assign relock_count = r_relock_cnt;

endmodule
